// File: rtl/instruction_memory_pkg.sv
// Shared constants for the instruction store: geometry, NOP word and boot image.
// The boot image is a short arithmetic/memory/branch demo program.
package instructionmemory_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 32;
  localparam int PROG_LEN = 26;

  localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

  localparam logic [DATA_W-1:0] BOOT_PROG [PROG_LEN] = '{
    32'h2008_0005, 32'h2009_000A, 32'h0109_5020, 32'h0128_5822,
    32'h0109_6024, 32'h0109_6825, 32'h0109_702A, 32'hAC0A_0000,
    32'h8C0F_0000, 32'h114F_0001, 32'h2010_0001, 32'h2011_0002,
    32'h0230_9020, 32'h0230_9822, 32'hAC12_0004, 32'h8C14_0004,
    32'h1254_0002, 32'h2015_0063, 32'h2016_0064, 32'h0800_0014,
    32'h2017_0007, 32'h02F7_C020, 32'h0317_C822, 32'hAC19_0008,
    32'h8C08_0008, 32'h0800_0000
  };

endpackage

// File: rtl/instruction_memory_override_ram.sv
// Word RAM with a per-word override flag; flags clear on async reset,
// data words keep their contents but become invisible until rewritten.
module override_ram #(
  parameter int ADDR_W = instructionmemory_pkg::ADDR_W,
  parameter int DATA_W = instructionmemory_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_hit,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  ovr;

  // Only the flags are reset; the reset branch leaves mem untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr <= '0;
    end else if (wr_en) begin
      ovr[wr_addr] <= 1'b1;
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_hit  = ovr[rd_addr];
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instruction_memory.sv
// Combinational instruction fetch: override word, else boot image, else NOP.
// Load port writes land on the next rising clk edge.
module instruction_memory #(
  parameter int ADDR_W   = instructionmemory_pkg::ADDR_W,
  parameter int DATA_W   = instructionmemory_pkg::DATA_W,
  parameter int PROG_LEN = instructionmemory_pkg::PROG_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] Instruction,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData
);

  import instructionmemory_pkg::NOP;
  import instructionmemory_pkg::BOOT_PROG;

  localparam int                BOOT_AW  = $clog2(PROG_LEN);
  localparam logic [ADDR_W-1:0] PROG_END = ADDR_W'(PROG_LEN);

  logic              hit;
  logic [DATA_W-1:0] ram_data;

  override_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (WrEn),
    .wr_addr (WrAddr),
    .wr_data (WrData),
    .rd_addr (Addr),
    .rd_hit  (hit),
    .rd_data (ram_data)
  );

  always_comb begin
    Instruction = DATA_W'(NOP);
    if (hit) begin
      Instruction = ram_data;
    end else if (Addr < PROG_END) begin
      Instruction = DATA_W'(BOOT_PROG[Addr[BOOT_AW-1:0]]);
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory: directed plan plus random
// load/fetch/reset traffic against an array-based reference model.
module tb_instruction_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  Addr;
  logic [31:0] Instruction;
  logic        WrEn;
  logic [9:0]  WrAddr;
  logic [31:0] WrData;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] boot [26] = '{
    32'h2008_0005, 32'h2009_000A, 32'h0109_5020, 32'h0128_5822,
    32'h0109_6024, 32'h0109_6825, 32'h0109_702A, 32'hAC0A_0000,
    32'h8C0F_0000, 32'h114F_0001, 32'h2010_0001, 32'h2011_0002,
    32'h0230_9020, 32'h0230_9822, 32'hAC12_0004, 32'h8C14_0004,
    32'h1254_0002, 32'h2015_0063, 32'h2016_0064, 32'h0800_0014,
    32'h2017_0007, 32'h02F7_C020, 32'h0317_C822, 32'hAC19_0008,
    32'h8C08_0008, 32'h0800_0000
  };

  logic [31:0] m_mem [1024];
  bit          m_ovr [1024];

  always #5 clk = ~clk;

  instruction_memory dut (
    .clk         (clk),
    .rst         (rst),
    .Addr        (Addr),
    .Instruction (Instruction),
    .WrEn        (WrEn),
    .WrAddr      (WrAddr),
    .WrData      (WrData)
  );

  // Reference: last written word wins; reset forgets every write.
  always @(posedge clk)
    if (WrEn === 1'b1 && rst === 1'b0) begin
      m_mem[WrAddr] = WrData;
      m_ovr[WrAddr] = 1'b1;
    end

  always @(posedge rst)
    foreach (m_ovr[i]) m_ovr[i] = 1'b0;

  function automatic logic [31:0] ref_word(int a);
    if (m_ovr[a]) return m_mem[a];
    if (a < 26) return boot[a];
    return 32'h0;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (Addr=%0d t=%0t)",
               tag, got, exp, Addr, $time);
    end
  endtask

  task automatic peek(string tag, int a);
    Addr = a[9:0];
    #1;
    check(tag, Instruction, ref_word(a));
  endtask

  initial begin
    rst = 1'b0; WrEn = 1'b0; WrAddr = '0; WrData = '0; Addr = '0;
    #2 rst = 1'b1;
    #1 check("rst_addr0", Instruction, 32'h2008_0005);
    @(negedge clk);
    rst = 1'b0;

    for (int a = 0; a < 26; a++) begin
      @(negedge clk);
      peek("sweep", a);
    end
    @(negedge clk); peek("sweep_a1", 1);
    check("boot1_const", Instruction, 32'h2009_000A);
    peek("sweep_a2", 2);
    check("boot2_const", Instruction, 32'h0109_5020);

    peek("nop26", 26);
    check("nop26_const", Instruction, 32'h0);
    peek("nop500", 500);
    peek("nop1023", 1023);

    // Override inside the program, Addr held on the written word.
    @(negedge clk);
    WrEn = 1'b1; WrAddr = 10'd1; WrData = 32'hDEAD_BEEF;
    peek("ovr_before", 1);
    check("ovr_before_c", Instruction, 32'h2009_000A);
    @(posedge clk);
    #1 check("ovr_after", Instruction, 32'hDEAD_BEEF);
    WrEn = 1'b0;
    @(negedge clk); peek("ovr_keep0", 0);

    // Override outside the program.
    @(negedge clk);
    WrEn = 1'b1; WrAddr = 10'd700; WrData = 32'h1234_5678;
    @(posedge clk);
    #1 WrEn = 1'b0;
    peek("wr700", 700);
    check("wr700_c", Instruction, 32'h1234_5678);
    peek("nop701", 701);

    // Reset between edges, then a write attempt while held.
    @(negedge clk);
    #2 rst = 1'b1;
    peek("arst_a1", 1);
    check("arst_a1_c", Instruction, 32'h2009_000A);
    peek("arst_a700", 700);
    check("arst_a700_c", Instruction, 32'h0);
    WrEn = 1'b1; WrAddr = 10'd1; WrData = 32'hCAFE_F00D;
    @(posedge clk);
    #1 peek("rst_wr_ign", 1);
    @(negedge clk);
    WrEn = 1'b0; rst = 1'b0;
    peek("rst_norestore", 1);
    peek("rst_norest700", 700);

    // Back-to-back writes to the same word.
    @(negedge clk);
    WrEn = 1'b1; WrAddr = 10'd5; WrData = 32'hAAAA_AAAA;
    @(negedge clk);
    WrData = 32'h5555_5555;
    @(negedge clk);
    WrEn = 1'b0;
    peek("b2b", 5);
    check("b2b_c", Instruction, 32'h5555_5555);

    // Random traffic with occasional mid-cycle resets.
    repeat (400) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 24) == 0);
      WrEn   = $urandom_range(0, 1) == 1;
      WrAddr = $urandom_range(0, 1) ? 10'($urandom_range(0, 31))
                                    : 10'($urandom);
      WrData = $urandom;
      case ($urandom_range(0, 2))
        0:       Addr = WrAddr;
        1:       Addr = 10'($urandom_range(0, 31));
        default: Addr = 10'($urandom);
      endcase
      peek("rnd_pre", int'(Addr));
      @(posedge clk);
      #1 peek("rnd_post", int'(Addr));
    end
    @(negedge clk);
    rst = 1'b0; WrEn = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
